// File: rtl/tri_func_checker.sv
// Sweep checker for three parallel logic-function variants: counts disagreements,
// latches the first failing vector and compacts all responses into a MISR.
module tri_func_checker #(
   parameter int               IN_W  = 5,
   parameter int               LAT   = 1,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   vec_in,
   input  logic              f1,
   input  logic              f2,
   input  logic              f3,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IN_W:0]     mism_cnt,
   output logic              first_mism_valid,
   output logic [IN_W-1:0]   first_mism_vec,
   output logic [SIG_W-1:0]  sig
);

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN, S_DONE} state_t;

   localparam logic [IN_W:0] LAST   = (IN_W+1)'((1 << IN_W) - 1);
   localparam logic [IN_W:0] ONE    = (IN_W+1)'(1);
   localparam logic [2:0]    LAT_M1 = 3'((LAT > 0) ? LAT - 1 : 0);

   state_t             state_q, state_d;
   logic [2:0]         align_q, align_d;
   logic [IN_W:0]      samp_q, samp_d;
   logic [IN_W:0]      cnt_q, cnt_d;
   logic               fmv_q, fmv_d;
   logic [IN_W-1:0]    fvec_q, fvec_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic               pass_q, pass_d;
   logic [IN_W-1:0]    vec_al;
   logic               mis;
   logic [SIG_W-1:0]   sig_step;

   // Delay vec_in so it lines up with the function stages' response latency.
   if (LAT == 0) begin : g_nolat
      assign vec_al = vec_in;
   end else begin : g_lat
      logic [LAT-1:0][IN_W-1:0] pipe_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_q <= '0;
         end else begin
            pipe_q[0] <= vec_in;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign vec_al = pipe_q[LAT-1];
   end

   assign mis      = !(f1 == f2 && f2 == f3);
   assign sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-3){1'b0}}, f3, f2, f1};

   always_comb begin
      state_d = state_q;
      align_d = align_q;
      samp_d  = samp_q;
      cnt_d   = cnt_q;
      fmv_d   = fmv_q;
      fvec_d  = fvec_q;
      sig_d   = sig_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = (LAT == 0) ? S_RUN : S_ALIGN;
               align_d = '0;
               samp_d  = '0;
               cnt_d   = '0;
               fmv_d   = 1'b0;
               fvec_d  = '0;
               sig_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_ALIGN: begin
            if (align_q == LAT_M1) state_d = S_RUN;
            else                   align_d = align_q + 3'd1;
         end
         S_RUN: begin
            if (mis) begin
               cnt_d = cnt_q + ONE;
               if (!fmv_q) begin
                  fmv_d  = 1'b1;
                  fvec_d = vec_al;
               end
            end
            sig_d  = sig_step;
            samp_d = samp_q + ONE;
            if (samp_q == LAST) begin
               state_d = S_DONE;
               pass_d  = (cnt_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         align_q <= '0;
         samp_q  <= '0;
         cnt_q   <= '0;
         fmv_q   <= 1'b0;
         fvec_q  <= '0;
         sig_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         align_q <= align_d;
         samp_q  <= samp_d;
         cnt_q   <= cnt_d;
         fmv_q   <= fmv_d;
         fvec_q  <= fvec_d;
         sig_q   <= sig_d;
         pass_q  <= pass_d;
      end
   end

   assign busy             = (state_q == S_ALIGN) || (state_q == S_RUN);
   assign done             = (state_q == S_DONE);
   assign pass             = pass_q;
   assign mism_cnt         = cnt_q;
   assign first_mism_valid = fmv_q;
   assign first_mism_vec   = fvec_q;
   assign sig              = sig_q;

endmodule

// File: tb/tb_tri_func_checker.sv
// Randomized bench: three checkers (LAT 0/1/3) fed by one counter, each with
// responses delayed to its latency, compared against a sweep-level model.
module tb_tri_func_checker;

   localparam int N = 32;
   localparam int LATS [3] = '{0, 1, 3};

   logic        clk, rst, start;
   logic [4:0]  vec_in;
   logic        f1_w [3], f2_w [3], f3_w [3];
   logic        busy_w [3], done_w [3], pass_w [3], fmv_w [3];
   logic [5:0]  cnt_w [3];
   logic [4:0]  fvec_w [3];
   logic [15:0] sig_w [3];

   logic [4:0]  hist [8];
   logic [31:0] tt1, tt2, tt3;
   int          total, bad;

   logic [5:0]  exp_cnt;
   logic        exp_fmv;
   logic [4:0]  exp_fvec;
   logic [15:0] exp_sig;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      tri_func_checker #(.IN_W(5), .LAT(LATS[g]), .SIG_W(16), .POLY(16'h1021)) u_dut (
         .clk(clk), .rst(rst), .start(start), .vec_in(vec_in),
         .f1(f1_w[g]), .f2(f2_w[g]), .f3(f3_w[g]),
         .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
         .mism_cnt(cnt_w[g]), .first_mism_valid(fmv_w[g]),
         .first_mism_vec(fvec_w[g]), .sig(sig_w[g]));
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; upstream counter increments, each DUT sees responses LAT old.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = hist[0] + 5'd1;
      vec_in  = hist[0];
      for (int d = 0; d < 3; d++) begin
         f1_w[d] = tt1[hist[LATS[d]]];
         f2_w[d] = tt2[hist[LATS[d]]];
         f3_w[d] = tt3[hist[LATS[d]]];
      end
   endtask

   // Sweep of N consecutive vectors starting at s, evaluated straight from the truth tables.
   task automatic model(input logic [4:0] s);
      logic [4:0] v;
      logic a, b, c;
      exp_cnt = 0; exp_fmv = 0; exp_fvec = 0; exp_sig = 0;
      for (int i = 0; i < N; i++) begin
         v = s + 5'(i);
         a = tt1[v]; b = tt2[v]; c = tt3[v];
         if (!(a == b && b == c)) begin
            exp_cnt++;
            if (!exp_fmv) begin
               exp_fmv  = 1;
               exp_fvec = v;
            end
         end
         exp_sig = 16'((exp_sig << 1) ^ (exp_sig[15] ? 16'h1021 : 16'h0) ^ {13'd0, c, b, a});
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_busy%0d", tag, d), busy_w[d], 0);
         chk($sformatf("%s_done%0d", tag, d), done_w[d], 0);
         chk($sformatf("%s_pass%0d", tag, d), pass_w[d], 0);
         chk($sformatf("%s_fmv%0d",  tag, d), fmv_w[d], 0);
         chk($sformatf("%s_cnt%0d",  tag, d), cnt_w[d], 0);
         chk($sformatf("%s_fvec%0d", tag, d), fvec_w[d], 0);
         chk($sformatf("%s_sig%0d",  tag, d), sig_w[d], 0);
      end
   endtask

   task automatic chk_res(input string tag, input int d);
      chk($sformatf("%s_cnt%0d",  tag, d), cnt_w[d], exp_cnt);
      chk($sformatf("%s_fmv%0d",  tag, d), fmv_w[d], exp_fmv);
      chk($sformatf("%s_fvec%0d", tag, d), fvec_w[d], exp_fvec);
      chk($sformatf("%s_sig%0d",  tag, d), sig_w[d], exp_sig);
      chk($sformatf("%s_pass%0d", tag, d), pass_w[d], (exp_cnt == 0));
   endtask

   task automatic run_sweep(input string tag, input bit hold);
      int done_at [3];
      int busy_n [3];
      model(vec_in + 5'd1);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         done_at[d] = -1;
         busy_n[d]  = 0;
      end
      for (int c = 0; c <= 40; c++) begin
         if (c > 0) tick();
         for (int d = 0; d < 3; d++) begin
            if (c == 0) chk($sformatf("%s_busy0_%0d", tag, d), busy_w[d], 1);
            if (done_at[d] < 0 && busy_w[d]) busy_n[d]++;
            if (done_at[d] < 0 && done_w[d]) begin
               done_at[d] = c;
               chk_res(tag, d);
            end else if (hold && done_at[d] >= 0 && c == done_at[d] + 1) begin
               chk($sformatf("%s_rbusy%0d", tag, d), busy_w[d], 1);
               chk($sformatf("%s_rdone%0d", tag, d), done_w[d], 0);
               chk($sformatf("%s_rcnt%0d",  tag, d), cnt_w[d], 0);
               chk($sformatf("%s_rsig%0d",  tag, d), sig_w[d], 0);
               chk($sformatf("%s_rfmv%0d",  tag, d), fmv_w[d], 0);
            end
         end
      end
      start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_doneat%0d", tag, d), done_at[d], LATS[d] + N);
         chk($sformatf("%s_busyn%0d",  tag, d), busy_n[d],  LATS[d] + N);
         if (!hold) begin
            chk($sformatf("%s_hold_done%0d", tag, d), done_w[d], 1);
            chk_res({tag, "_stable"}, d);
         end
      end
   endtask

   task automatic rand_tables();
      tt1 = $urandom;
      tt2 = tt1;
      tt3 = tt1;
      case ($urandom_range(0, 3))
         0: ;
         1: tt2 = tt1 ^ (32'd1 << $urandom_range(0, 31));
         2: tt3 = tt1 ^ ($urandom & $urandom & $urandom);
         default: begin tt2 = $urandom; tt3 = $urandom; end
      endcase
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; vec_in = '0;
      tt1 = '0; tt2 = '0; tt3 = '0;
      for (int i = 0; i < 8; i++) hist[i] = '0;
      for (int d = 0; d < 3; d++) begin
         f1_w[d] = 0; f2_w[d] = 0; f3_w[d] = 0;
      end
      repeat (3) tick();
      chk_zero("reset");
      rst = 1'b0;
      repeat (4) tick();

      run_sweep("zero", 0);

      tt1 = 32'hAAAA_AAAA; tt3 = tt1; tt2 = tt1 ^ (32'd1 << 7);
      repeat (3) tick();
      run_sweep("one7", 0);

      tt1 = 32'hFFFF_FFFF; tt2 = '0; tt3 = '0;
      repeat (5) tick();
      run_sweep("all", 0);

      tt1 = $urandom; tt2 = tt1 ^ 32'h0001_0420; tt3 = tt1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();
      rst = 1'b1;
      tick();
      chk_zero("midrst");
      rst = 1'b0;
      tick();
      run_sweep("afterrst", 0);

      tt1 = 32'h1234_5678; tt2 = 32'h1234_5679; tt3 = tt1;
      run_sweep("hold", 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (4) tick();

      for (int r = 0; r < 8; r++) begin
         rand_tables();
         repeat ($urandom_range(0, 6)) tick();
         run_sweep($sformatf("rnd%0d", r), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tri_func_checker.md
Name: tri_func_checker

Overview:
- Downstream consumer of the three parallel 5-input logic-function stages (variants 1/2/3), all driven by a common incrementing input vector.
- Over one full sweep of 2^IN_W vectors it checks that the three function outputs agree on every vector.
- It counts disagreements, records the first disagreeing vector and compacts all outputs into a MISR signature.
- Results are used for on-board self-check and for bench comparison against a golden signature.

Parameters:
IN_W, 5, width of the applied input vector; sweep length N = 2^IN_W samples
LAT, 1, clock cycles from vec_in change to corresponding f1/f2/f3 response (0..7)
SIG_W, 16, signature register width (>= 4)
POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a sweep; honoured only in IDLE or DONE
vec_in  in  IN_W  input vector currently applied to the function stages
f1  in  1  output of function variant 1
f2  in  1  output of function variant 2
f3  in  1  output of function variant 3
busy  out  1  high in ALIGN and RUN
done  out  1  high in DONE (level, held until start or rst)
pass  out  1  valid while done: 1 when mism_cnt == 0
mism_cnt  out  IN_W+1  number of sampled vectors with disagreeing outputs
first_mism_valid  out  1  a mismatch has been recorded this sweep
first_mism_vec  out  IN_W  aligned vector of the first mismatch
sig  out  SIG_W  MISR signature of {f3,f2,f1} over the sweep

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. busy, done, pass, first_mism_valid are 0. mism_cnt, first_mism_vec and sig are 0. The alignment pipeline is cleared to 0. Reset has priority over all other inputs, including mid-sweep; a partial sweep is discarded.
- Alignment pipeline: LAT-deep shift register of vec_in, shifting every cycle in all states. vec_al = vec_in delayed LAT cycles (vec_al = vec_in when LAT=0).
- FSM states and transitions:
  - IDLE: on start=1 go to ALIGN; if LAT=0 go directly to RUN.
  - ALIGN: wait exactly LAT cycles (3-bit counter), then go to RUN.
  - RUN: exactly N sample cycles (IN_W+1-bit sample counter), then go to DONE.
  - DONE: on start=1 go to ALIGN/RUN, as from IDLE.
- start while busy is ignored.
- On entry to a sweep (start accepted) mism_cnt, sig, first_mism_valid, first_mism_vec and pass are cleared in the same edge.
- RUN sample cycle, with mis = !(f1==f2 && f2==f3):
  - If mis: mism_cnt += 1. Saturation is never needed, since max = N fits in IN_W+1 bits.
  - If mis and !first_mism_valid: first_mism_vec <= vec_al and first_mism_valid <= 1. Later mismatches do not overwrite it.
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {{SIG_W-3{1'b0}}, f3, f2, f1}.
- pass is registered on the RUN->DONE edge as (final mism_cnt == 0) and held through DONE.
- Outputs are stable in DONE; none change until the next accepted start or rst.
- Timing (LAT=1, N=32):
  - start sampled at edge k; busy=1 from k+1.
  - ALIGN occupies cycle k+1; samples are taken at edges k+2..k+33.
  - done=1 and busy=0 from k+34.
- No dependence on vec_in values for sweep length. Wrap-around of the upstream counter is transparent: the block samples whatever vec_al is presented for N consecutive cycles.

Test Plan:
- f1=f2=f3=0 constant, LAT=1, start pulse -> busy for 33 cycles, then done=1, pass=1, mism_cnt=0, first_mism_valid=0, sig=16'h0000.
- Upstream counter 0..31, f1=f2=f3=vec_al[0] except f2 inverted when vec_al==7 -> mism_cnt=1, first_mism_valid=1, first_mism_vec=7, pass=0.
- f1=1, f2=0, f3=0 constant -> mism_cnt=32 (6'b100000), first_mism_vec equals vec_al on the first RUN cycle, pass=0.
- rst asserted at sample 10 of a sweep with mismatches present -> next cycle state IDLE, all outputs 0. A new start gives a full 32-sample sweep with results identical to an undisturbed run.
- start held high throughout a sweep -> extra starts ignored while busy. In DONE, start restarts the sweep, clearing results on the same edge.
- Same stimulus with LAT=0 and LAT=3 (DUT responses delayed accordingly) -> identical mism_cnt, first_mism_vec and sig. done rises at k+33 and k+36 respectively.
